// File: rtl/cdc_pkg.sv
// Shared types and default sizes for the four-phase REQ/ACK crossing receiver.
package cdc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StPresent = 2'b01,
    StAckHi   = 2'b10
  } state_e;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefNumStages = 2;
  localparam int unsigned DefCntWidth  = 16;

endpackage

// File: rtl/cdc_hs_rx_if.sv
// Signal bundle between the source-domain sender, the local consumer and cdc_hs_rx.
interface cdc_hs_rx_if
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) ();

  logic                  REQ_ASYNC;
  logic [DATA_WIDTH-1:0] DATA_ASYNC;
  logic                  DEST_READY;
  logic                  ERR_CLR;
  logic                  ACK;
  logic [DATA_WIDTH-1:0] SYNC_DATA;
  logic                  DATA_VALID;
  logic                  BUSY;
  logic [CNT_WIDTH-1:0]  XFER_CNT;
  logic                  PROTO_ERR;

  modport master (
    output REQ_ASYNC, DATA_ASYNC, DEST_READY, ERR_CLR,
    input  ACK, SYNC_DATA, DATA_VALID, BUSY, XFER_CNT, PROTO_ERR
  );

  modport slave (
    input  REQ_ASYNC, DATA_ASYNC, DEST_READY, ERR_CLR,
    output ACK, SYNC_DATA, DATA_VALID, BUSY, XFER_CNT, PROTO_ERR
  );

endinterface

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single-bit level crossing into the CLK domain.
module sync_chain
  import cdc_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DefNumStages
) (
  input  logic CLK,
  input  logic RST,
  input  logic d_i,
  output logic q_o
);

  logic [NUM_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], d_i};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/cdc_hs_rx.sv
// Receive side of a four-phase REQ/ACK bus crossing: synchronise REQ, capture the held
// bus, hand it to the local consumer via valid/ready and return ACK to the source.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned NUM_STAGES = DefNumStages,
  parameter int unsigned CNT_WIDTH  = DefCntWidth
) (
  input logic        CLK,
  input logic        RST,
  cdc_hs_rx_if.slave bus
);

  logic                  req_s;
  state_e                state_q, state_d;
  logic                  ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d, err_set;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  sync_chain #(
    .NUM_STAGES(NUM_STAGES)
  ) u_req_sync (
    .CLK(CLK),
    .RST(RST),
    .d_i(bus.REQ_ASYNC),
    .q_o(req_s)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_s) begin
          data_d  = bus.DATA_ASYNC;
          valid_d = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        // Source withdrew REQ before the consumer took the data: drop it and flag.
        if (!req_s) begin
          valid_d = 1'b0;
          err_set = 1'b1;
          state_d = StIdle;
        end else if (valid_q && bus.DEST_READY) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + CNT_WIDTH'(1);
          state_d = StAckHi;
        end
      end
      StAckHi: begin
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    err_d = err_set | (err_q & ~bus.ERR_CLR);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ACK        = ack_q;
  assign bus.SYNC_DATA  = data_q;
  assign bus.DATA_VALID = valid_q;
  assign bus.BUSY       = (state_q != StIdle);
  assign bus.XFER_CNT   = cnt_q;
  assign bus.PROTO_ERR  = err_q;

endmodule

// File: tb/tb_cdc_hs_rx.sv
// Randomised bench for cdc_hs_rx: a source/consumer driver pushes expected words into a
// queue, and an independent monitor pops one each time ACK rises.
module tb_cdc_hs_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 2;
  localparam int unsigned CW = 4;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  cdc_hs_rx_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  cdc_hs_rx #(
    .DATA_WIDTH(DW),
    .NUM_STAGES(NS),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  int unsigned   exp_cnt = 0;
  logic          exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive/sample point: 2 time units after the active edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Waits for DATA_VALID with REQ already high; latency is counted in edges from now.
  task automatic wait_capture(input logic [DW-1:0] data);
    int n;
    n = 0;
    do begin
      bus.DEST_READY = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!bus.DATA_VALID && n < 20);
    bus.DEST_READY = 1'b0;
    check("capture latency", n, NS + 1);
    check("captured data", bus.SYNC_DATA, data);
    check("busy in present", bus.BUSY, 1'b1);
  endtask

  task automatic capture(input logic [DW-1:0] data);
    bus.DATA_ASYNC = data;
    bus.REQ_ASYNC  = 1'b1;
    wait_capture(data);
  endtask

  task automatic accept(input logic [DW-1:0] data, input int hold);
    repeat (hold) begin
      tick();
      check("backpressure valid held", bus.DATA_VALID, 1'b1);
      check("backpressure data held", bus.SYNC_DATA, data);
      check("backpressure ack low", bus.ACK, 1'b0);
    end
    bus.DEST_READY = 1'b1;
    tick();
    bus.DEST_READY = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    check("ack on accept", bus.ACK, 1'b1);
    check("valid drops on accept", bus.DATA_VALID, 1'b0);
    check("count on accept", bus.XFER_CNT, exp_cnt);
  endtask

  task automatic release_req(input int ack_hold);
    int n;
    repeat (ack_hold) begin
      tick();
      check("ack held while req", bus.ACK, 1'b1);
    end
    bus.REQ_ASYNC = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ACK && n < 20);
    bus.DATA_ASYNC = DW'($urandom);
    check("ack release latency", n, NS + 1);
    check("idle after release", bus.BUSY, 1'b0);
    check("error flag after xfer", bus.PROTO_ERR, exp_err);
    check("count after xfer", bus.XFER_CNT, exp_cnt);
  endtask

  task automatic xfer(input logic [DW-1:0] data, input int hold);
    capture(data);
    exp_q.push_back(data);
    accept(data, hold);
    release_req($urandom_range(0, 3));
  endtask

  // REQ withdrawn while presenting; DEST_READY is raised on the very edge that sees req_s
  // low, so the error path must win. clr_same pulses ERR_CLR on that same edge.
  task automatic xfer_err(input logic [DW-1:0] data, input int hold, input logic clr_same);
    capture(data);
    repeat (hold) tick();
    bus.REQ_ASYNC = 1'b0;
    tick();
    tick();
    check("valid before req_s drops", bus.DATA_VALID, 1'b1);
    bus.DEST_READY = 1'b1;
    bus.ERR_CLR    = clr_same;
    tick();
    bus.DEST_READY = 1'b0;
    bus.ERR_CLR    = 1'b0;
    exp_err = 1'b1;
    check("error flag set", bus.PROTO_ERR, 1'b1);
    check("error valid dropped", bus.DATA_VALID, 1'b0);
    check("error no ack", bus.ACK, 1'b0);
    check("error back to idle", bus.BUSY, 1'b0);
    check("error count unchanged", bus.XFER_CNT, exp_cnt);
    tick();
    check("no late ack after error", bus.ACK, 1'b0);
  endtask

  task automatic clear_err();
    bus.ERR_CLR = 1'b1;
    tick();
    bus.ERR_CLR = 1'b0;
    exp_err = 1'b0;
    check("error flag cleared", bus.PROTO_ERR, 1'b0);
  endtask

  // Scoreboard monitor: every ACK rising edge is one delivered word.
  initial begin
    logic ack_prev;
    ack_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        ack_prev = 1'b0;
      end else begin
        if (bus.ACK && !ack_prev) begin
          if (exp_q.size() == 0) check("unexpected ack", 1'b1, 1'b0);
          else check("scoreboard data", bus.SYNC_DATA, exp_q.pop_front());
        end
        ack_prev = bus.ACK;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    bus.REQ_ASYNC  = 1'b0;
    bus.DATA_ASYNC = '0;
    bus.DEST_READY = 1'b0;
    bus.ERR_CLR    = 1'b0;
    RST            = 1'b0;
    repeat (3) tick();
    check("reset ack", bus.ACK, 1'b0);
    check("reset sync_data", bus.SYNC_DATA, 0);
    check("reset valid", bus.DATA_VALID, 1'b0);
    check("reset busy", bus.BUSY, 1'b0);
    check("reset count", bus.XFER_CNT, 0);
    check("reset error", bus.PROTO_ERR, 1'b0);
    RST = 1'b1;
    repeat (2) tick();

    // Nominal transfer, then a 10-cycle backpressure transfer.
    xfer(8'hA5, 0);
    xfer(DW'($urandom), 10);

    // Protocol errors: plain set, ERR_CLR alone, then set racing ERR_CLR.
    xfer_err(DW'($urandom), 2, 1'b0);
    clear_err();
    xfer_err(DW'($urandom), 0, 1'b1);
    clear_err();

    // Reset while in ACK_HI with REQ still high: re-delivery after release.
    d = DW'($urandom);
    capture(d);
    exp_q.push_back(d);
    accept(d, 1);
    tick();
    RST = 1'b0;
    #1;
    check("mid reset ack", bus.ACK, 1'b0);
    check("mid reset sync_data", bus.SYNC_DATA, 0);
    check("mid reset valid", bus.DATA_VALID, 1'b0);
    check("mid reset busy", bus.BUSY, 1'b0);
    check("mid reset count", bus.XFER_CNT, 0);
    exp_cnt = 0;
    exp_err = 1'b0;
    tick();
    RST = 1'b1;
    wait_capture(d);
    exp_q.push_back(d);
    accept(d, 0);
    release_req(0);

    // 16 more transfers after the re-delivery: 17 since reset wraps a 4-bit count to 1.
    for (int i = 0; i < 16; i++) xfer(DW'($urandom), $urandom_range(0, 4));
    check("counter wrap", bus.XFER_CNT, 1);

    // Randomised mix of good transfers and aborted ones.
    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        xfer_err(DW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) clear_err();
      end else begin
        xfer(DW'($urandom), $urandom_range(0, 6));
      end
    end

    repeat (4) tick();
    check("scoreboard drained", exp_q.size(), 0);
    check("final count", bus.XFER_CNT, exp_cnt);
    check("final error flag", bus.PROTO_ERR, exp_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
